// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-memory completer.
package apb_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam logic [ADDR_W-1:0] ADDR_MIN = 8'h05;
   localparam logic [ADDR_W-1:0] ADDR_MAX = 8'hF1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   // Transfer attributes captured on the SETUP->ACCESS edge
   typedef struct packed {
      logic              write;
      logic              err;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } xfer_t;

   function automatic logic addr_invalid(input logic [ADDR_W-1:0] a);
      return (a < ADDR_MIN) || (a > ADDR_MAX);
   endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB bus signals between requester and completer.
interface apb_slave_if;
   import apb_pkg::*;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_slave_mem.sv
// 256x8 storage: synchronous clear, one write port, asynchronous read port.
module apb_slave_mem
   import apb_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always_ff @(posedge clk) begin
      if (clr) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave.sv
// APB completer: protocol FSM, address range check and sticky protocol error
// in front of a 256x8 register memory.
module apb_slave
   import apb_pkg::*;
(
   input logic        PCLK,
   input logic        RSTN,
   apb_slave_if.slave bus
);

   state_t            current_state, next_state;
   logic              invalid_addr;
   logic              protocol_error;
   logic              violation;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   xfer_t             xfer;

   assign invalid_addr = addr_invalid(bus.PADDR);
   assign bus.PREADY   = (current_state == ACCESS);
   assign mem_we       = bus.PREADY && xfer.write && !xfer.err && !protocol_error;

   always_comb begin
      next_state = current_state;
      violation  = 1'b0;
      unique case (current_state)
         IDLE: begin
            if (bus.PSEL && !bus.PENABLE) next_state = SETUP;
            else if (bus.PSEL && bus.PENABLE) violation = 1'b1;
         end
         SETUP: begin
            if (!bus.PSEL) next_state = IDLE;
            else if (bus.PENABLE) next_state = ACCESS;
         end
         ACCESS:  next_state = bus.PSEL ? SETUP : IDLE;
         default: next_state = IDLE;
      endcase
      // A latched or freshly detected violation parks the FSM
      if (protocol_error || violation) next_state = IDLE;
   end

   always_ff @(posedge PCLK) begin
      if (RSTN) begin
         current_state  <= IDLE;
         protocol_error <= 1'b0;
         bus.PRDATA     <= '0;
         bus.PSLVERR    <= 1'b0;
         xfer           <= '0;
      end else begin
         current_state <= next_state;
         if (violation) protocol_error <= 1'b1;
         if (protocol_error || violation) begin
            bus.PSLVERR <= 1'b1;
         end else if (current_state == SETUP && next_state == ACCESS) begin
            xfer <= '{write: bus.PWRITE, err: invalid_addr,
                      addr: bus.PADDR, data: bus.PWDATA};
            bus.PSLVERR <= invalid_addr;
            if (!bus.PWRITE) bus.PRDATA <= invalid_addr ? '0 : mem_rdata;
         end else if (current_state == ACCESS) begin
            bus.PSLVERR <= 1'b0;
         end
      end
   end

   apb_slave_mem u_mem (
      .clk   (PCLK),
      .clr   (RSTN),
      .we    (mem_we),
      .waddr (xfer.addr),
      .wdata (xfer.data),
      .raddr (bus.PADDR),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_apb_slave.sv
// Randomized APB traffic against a transaction-level memory model, plus
// directed scenarios with literal expectations.
module tb_apb_slave;
   import apb_pkg::*;

   logic PCLK = 1'b0;
   logic RSTN;

   apb_slave_if bus();

   apb_slave dut (
      .PCLK (PCLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   always #5 PCLK = ~PCLK;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem_m [256];
   bit         exp_ready = 1'b0;
   bit         exp_err   = 1'b0;
   logic [7:0] exp_rdata = 8'h00;
   bit         cmp_en    = 1'b0;
   bit         in_setup  = 1'b0;
   logic [7:0] edges [8] = '{8'h00, 8'h04, 8'h05, 8'h06, 8'hF0, 8'hF1, 8'hF2, 8'hFF};
   logic [7:0] pool  [8] = '{8'h10, 8'h22, 8'h37, 8'h50, 8'h81, 8'hB1, 8'hCA, 8'hE9};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge PCLK) begin
      if (cmp_en) begin
         chk("PREADY",  32'(bus.PREADY),  32'(exp_ready));
         chk("PSLVERR", 32'(bus.PSLVERR), 32'(exp_err));
         chk("PRDATA",  32'(bus.PRDATA),  32'(exp_rdata));
      end
   end

   function automatic bit bad(input logic [7:0] a);
      return (a < 8'h05) || (a > 8'hF1);
   endfunction

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic drive_rand();
      bus.PWRITE = 1'($urandom);
      bus.PADDR  = 8'($urandom);
      bus.PWDATA = 8'($urandom);
   endtask

   // Bus inputs look like a protocol violation during reset; reset must win
   task automatic do_reset();
      RSTN = 1'b1;
      bus.PSEL = 1'b1;
      bus.PENABLE = 1'b1;
      drive_rand();
      tick();
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = 8'h00;
      in_setup  = 1'b0;
      bus.PSEL = 1'b0;
      bus.PENABLE = 1'b0;
      RSTN = 1'b0;
      cmp_en = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         bus.PSEL = 1'b0;
         bus.PENABLE = 1'b0;
         drive_rand();
         tick();
      end
      in_setup = 1'b0;
   endtask

   task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit hold, input bit keep_en,
                       output logic [7:0] rd, output logic err);
      if (!in_setup) begin
         bus.PSEL = 1'b1;
         bus.PENABLE = 1'b0;
         drive_rand();
         tick();
      end
      bus.PWRITE = w;
      bus.PADDR = a;
      bus.PWDATA = d;
      bus.PENABLE = 1'b1;
      tick();
      exp_ready = 1'b1;
      exp_err = bad(a);
      if (!w) exp_rdata = bad(a) ? 8'h00 : mem_m[a];
      rd = bus.PRDATA;
      err = bus.PSLVERR;
      bus.PSEL = hold;
      bus.PENABLE = hold && keep_en;
      tick();
      if (w && !bad(a)) mem_m[a] = d;
      exp_ready = 1'b0;
      exp_err = 1'b0;
      in_setup = hold;
   endtask

   task automatic chk_mem();
      for (int i = 0; i < 256; i++)
         chk($sformatf("mem[%0h]", i), 32'(dut.u_mem.mem[i[7:0]]), 32'(mem_m[i]));
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic e);
      logic [7:0] rd;
      logic err;
      xfer(1'b1, a, d, 1'b0, 1'b0, rd, err);
      chk($sformatf("wr_err@%0h", a), 32'(err), 32'(e));
   endtask

   task automatic rdc(input logic [7:0] a, input logic [7:0] v, input logic e, input bit hold);
      logic [7:0] rd;
      logic err;
      xfer(1'b0, a, 8'h00, hold, 1'b0, rd, err);
      chk($sformatf("rd_data@%0h", a), 32'(rd), 32'(v));
      chk($sformatf("rd_err@%0h", a), 32'(err), 32'(e));
   endtask

   initial begin
      RSTN = 1'b1;
      bus.PSEL = 1'b0;
      bus.PENABLE = 1'b0;
      drive_rand();
      do_reset();
      chk("reset_state", 32'(dut.current_state), 32'(IDLE));
      chk("reset_perr", 32'(dut.protocol_error), 32'h0);
      idle(2);

      wr(8'hCA, 8'h55, 1'b0);
      wr(8'h37, 8'hAA, 1'b0);
      wr(8'hB1, 8'h0F, 1'b0);
      rdc(8'hCA, 8'h55, 1'b0, 1'b1);
      rdc(8'h37, 8'hAA, 1'b0, 1'b1);
      rdc(8'h07, 8'h00, 1'b0, 1'b1);
      rdc(8'hB1, 8'h0F, 1'b0, 1'b0);
      idle(1);

      wr(8'hFF, 8'hAA, 1'b1);
      wr(8'hB1, 8'h0F, 1'b0);
      wr(8'h01, 8'h0F, 1'b1);
      chk("mem_FF", 32'(dut.u_mem.mem[8'hFF]), 32'h0);
      chk("mem_01", 32'(dut.u_mem.mem[8'h01]), 32'h0);
      rdc(8'hB1, 8'h0F, 1'b0, 1'b0);
      rdc(8'hFF, 8'h00, 1'b1, 1'b0);
      rdc(8'h01, 8'h00, 1'b1, 1'b0);
      rdc(8'hB1, 8'h0F, 1'b0, 1'b0);

      wr(8'h05, 8'h11, 1'b0);
      wr(8'hF1, 8'h22, 1'b0);
      wr(8'h04, 8'h33, 1'b1);
      wr(8'hF2, 8'h44, 1'b1);
      rdc(8'h05, 8'h11, 1'b0, 1'b0);
      rdc(8'hF1, 8'h22, 1'b0, 1'b0);
      rdc(8'h04, 8'h00, 1'b1, 1'b0);
      rdc(8'hF2, 8'h00, 1'b1, 1'b0);
      idle(1);

      // Select pulse without an access phase
      bus.PSEL = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE = 1'b1;
      bus.PADDR = 8'h50;
      bus.PWDATA = 8'hAB;
      tick();
      chk("pulse_setup", 32'(dut.current_state), 32'(SETUP));
      bus.PSEL = 1'b0;
      tick();
      chk("pulse_idle", 32'(dut.current_state), 32'(IDLE));
      chk("pulse_mem50", 32'(dut.u_mem.mem[8'h50]), 32'h0);
      idle(1);

      for (int n = 0; n < 400; n++) begin
         logic [7:0] a;
         logic [7:0] rd;
         logic err;
         bit hold;
         case ($urandom_range(0, 3))
            0:       a = edges[$urandom_range(0, 7)];
            1:       a = 8'($urandom);
            default: a = pool[$urandom_range(0, 7)];
         endcase
         hold = ($urandom_range(0, 2) != 0);
         xfer(1'($urandom), a, 8'($urandom), hold, 1'($urandom), rd, err);
         if (!hold && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);
      chk_mem();

      // Protocol violation from IDLE, then further traffic must be inert
      bus.PSEL = 1'b1;
      bus.PENABLE = 1'b1;
      bus.PWRITE = 1'b1;
      bus.PWDATA = 8'h55;
      bus.PADDR = 8'hCA;
      tick();
      exp_err = 1'b1;
      chk("perr_set", 32'(dut.protocol_error), 32'h1);
      bus.PADDR = 8'h37;
      tick();
      bus.PADDR = 8'hB1;
      tick();
      bus.PENABLE = 1'b0;
      tick();
      bus.PENABLE = 1'b1;
      tick();
      repeat (20) begin
         bus.PSEL = 1'($urandom);
         bus.PENABLE = 1'($urandom);
         drive_rand();
         tick();
      end
      chk("perr_state", 32'(dut.current_state), 32'(IDLE));
      chk("perr_hold", 32'(dut.protocol_error), 32'h1);
      chk("perr_slverr", 32'(bus.PSLVERR), 32'h1);
      chk_mem();
      do_reset();
      chk("perr_cleared", 32'(dut.protocol_error), 32'h0);
      chk("perr_rst_state", 32'(dut.current_state), 32'(IDLE));
      idle(1);

      // Reset arriving while a write is in its access cycle
      bus.PSEL = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE = 1'b1;
      bus.PADDR = 8'h60;
      bus.PWDATA = 8'h9C;
      tick();
      bus.PENABLE = 1'b1;
      tick();
      exp_ready = 1'b1;
      do_reset();
      chk("midxfer_mem60", 32'(dut.u_mem.mem[8'h60]), 32'h0);
      idle(1);

      wr(8'h22, 8'h5A, 1'b0);
      wr(8'h81, 8'hC3, 1'b0);
      wr(8'hE9, 8'h7E, 1'b0);
      rdc(8'h81, 8'hC3, 1'b0, 1'b0);
      idle(2);
      do_reset();
      chk_mem();
      chk("final_prdata", 32'(bus.PRDATA), 32'h0);
      chk("final_slverr", 32'(bus.PSLVERR), 32'h0);
      chk("final_state", 32'(dut.current_state), 32'(IDLE));
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
